// File: rtl/lift_car_pkg.sv
// Shared lift types and constants: cabin state encoding, floor numbering and
// tick counter width, plus floor-arithmetic helpers used by the cabin model.
package lift_pkg;

   localparam int unsigned TICK_W = 8;

   localparam logic [1:0] FLOOR0    = 2'd0;
   localparam logic [1:0] FLOOR1    = 2'd1;
   localparam logic [1:0] FLOOR2    = 2'd2;
   localparam logic [1:0] TOP_FLOOR = FLOOR2;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN,
      DOOR_CLOSE
   } car_state_t;

   function automatic logic move_legal(input logic [1:0] floor, input logic up);
      return up ? (floor < TOP_FLOOR) : (floor > FLOOR0);
   endfunction

   // Saturating step keeps the floor inside 0..TOP_FLOOR even on a bad request.
   function automatic logic [1:0] step_floor(input logic [1:0] floor, input logic up);
      logic [1:0] nxt;
      nxt = floor;
      if (up && floor < TOP_FLOOR)
         nxt = floor + 2'd1;
      else if (!up && floor > FLOOR0)
         nxt = floor - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/lift_car_if.sv
// Command/response bundle between the lift controller (master) and the cabin
// responder (slave), including the shared slowref pacing strobe.
interface lift_car_if;

   logic       slowref;
   logic       move_req;
   logic       move_up;
   logic       door_req;
   logic       move_ack;
   logic       fault;
   logic       moving;
   logic       dir_up;
   logic [1:0] floorno;
   logic       arrive;
   logic       door_open;
   logic       door_closing;

   modport master (
      output slowref, move_req, move_up, door_req,
      input  move_ack, fault, moving, dir_up, floorno, arrive, door_open, door_closing
   );

   modport slave (
      input  slowref, move_req, move_up, door_req,
      output move_ack, fault, moving, dir_up, floorno, arrive, door_open, door_closing
   );

endinterface

// File: rtl/lift_car_tick_timer.sv
// Strobe-paced phase counter: counts slowref strobes and flags the terminal
// strobe of a phase lasting i_limit strobes.
module tick_timer
   import lift_pkg::*;
(
   input  logic              clk,
   input  logic              resetb,
   input  logic              i_slowref,
   input  logic              i_clear,
   input  logic [TICK_W-1:0] i_limit,
   output logic              o_done
);

   logic [TICK_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!resetb || i_clear)
         r_count <= '0;
      else if (i_slowref)
         r_count <= r_count + 1'b1;
   end

   assign o_done = i_slowref && (r_count == i_limit - 1'b1);

endmodule

// File: rtl/lift_car.sv
// Cabin motion and door responder: accepts move/door commands, times travel and
// door phases on slowref, and reports floor, arrival and door status.
module lift_car
   import lift_pkg::*;
#(
   parameter int unsigned TRAVEL_TICKS = 16,
   parameter int unsigned DOOR_TICKS   = 32,
   parameter int unsigned CLOSE_TICKS  = 8
) (
   input logic        clk,
   input logic        resetb,
   lift_car_if.slave  car
);

   car_state_t        r_state;
   logic [1:0]        r_floor;
   logic              r_move_ack;
   logic              r_fault;
   logic              r_moving;
   logic              r_dir_up;
   logic              r_arrive;
   logic              r_door_open;
   logic              r_door_closing;

   logic [TICK_W-1:0] w_limit;
   logic              w_clear;
   logic              w_done;

   always_comb begin
      w_limit = TICK_W'(TRAVEL_TICKS);
      case (r_state)
         DOOR_OPEN:  w_limit = TICK_W'(DOOR_TICKS);
         DOOR_CLOSE: w_limit = TICK_W'(CLOSE_TICKS);
         default:    w_limit = TICK_W'(TRAVEL_TICKS);
      endcase
   end

   // Counter is held at zero in IDLE and cleared on every phase change or door restart.
   always_comb begin
      w_clear = 1'b1;
      case (r_state)
         IDLE:       w_clear = 1'b1;
         MOVING:     w_clear = w_done;
         DOOR_OPEN:  w_clear = car.door_req || w_done;
         DOOR_CLOSE: w_clear = car.door_req || w_done;
         default:    w_clear = 1'b1;
      endcase
   end

   tick_timer u_timer (
      .clk       (clk),
      .resetb    (resetb),
      .i_slowref (car.slowref),
      .i_clear   (w_clear),
      .i_limit   (w_limit),
      .o_done    (w_done)
   );

   always_ff @(posedge clk) begin
      if (!resetb) begin
         r_state        <= IDLE;
         r_floor        <= FLOOR0;
         r_move_ack     <= 1'b0;
         r_fault        <= 1'b0;
         r_moving       <= 1'b0;
         r_dir_up       <= 1'b0;
         r_arrive       <= 1'b0;
         r_door_open    <= 1'b0;
         r_door_closing <= 1'b0;
      end else begin
         r_move_ack <= 1'b0;
         r_fault    <= 1'b0;
         r_arrive   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (car.door_req) begin
                  r_door_open <= 1'b1;
                  r_state     <= DOOR_OPEN;
               // A request still high in the ack cycle is the same request; do not ack it twice.
               end else if (car.move_req && !r_move_ack) begin
                  r_move_ack <= 1'b1;
                  if (move_legal(r_floor, car.move_up)) begin
                     r_dir_up <= car.move_up;
                     r_moving <= 1'b1;
                     r_state  <= MOVING;
                  end else begin
                     r_fault <= 1'b1;
                  end
               end
            end
            MOVING: begin
               if (w_done) begin
                  r_floor     <= step_floor(r_floor, r_dir_up);
                  r_arrive    <= 1'b1;
                  r_moving    <= 1'b0;
                  r_door_open <= 1'b1;
                  r_state     <= DOOR_OPEN;
               end
            end
            DOOR_OPEN: begin
               if (!car.door_req && w_done) begin
                  r_door_open    <= 1'b0;
                  r_door_closing <= 1'b1;
                  r_state        <= DOOR_CLOSE;
               end
            end
            DOOR_CLOSE: begin
               if (car.door_req) begin
                  r_door_closing <= 1'b0;
                  r_door_open    <= 1'b1;
                  r_state        <= DOOR_OPEN;
               end else if (w_done) begin
                  r_door_closing <= 1'b0;
                  r_state        <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign car.move_ack     = r_move_ack;
   assign car.fault        = r_fault;
   assign car.moving       = r_moving;
   assign car.dir_up       = r_dir_up;
   assign car.floorno      = r_floor;
   assign car.arrive       = r_arrive;
   assign car.door_open    = r_door_open;
   assign car.door_closing = r_door_closing;

endmodule

// File: tb/tb_lift_car.sv
// Scoreboard bench for lift_car: stimulus pushes expected cabin events computed
// from floor/phase rules; a monitor pops them as the DUT produces events.
module tb_lift_car;

   localparam int TRAVEL = 4;
   localparam int DOOR   = 6;
   localparam int CLOSE  = 2;

   localparam int EV_ACK    = 0;
   localparam int EV_ARRIVE = 1;
   localparam int EV_OPEN   = 2;
   localparam int EV_CLOSE  = 3;
   localparam int EV_IDLE   = 4;

   typedef struct {
      int kind;
      int floor;
      int strobes;
      bit fault;
      bit dir;
   } exp_t;

   logic clk;
   logic resetb;
   lift_car_if bus();

   int   errors = 0;
   int   checks = 0;
   int   mfloor = 0;
   exp_t exp_q[$];

   lift_car #(
      .TRAVEL_TICKS (TRAVEL),
      .DOOR_TICKS   (DOOR),
      .CLOSE_TICKS  (CLOSE)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .car    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // slowref: one-cycle strobe every 4 clocks
   initial begin
      int cyc;
      cyc = 0;
      bus.slowref = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.slowref = (cyc % 4 == 0);
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected 0 pending events, got %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push(input int kind, input int floor, input int strobes,
                                input bit fault, input bit dir);
      exp_t e;
      e.kind = kind; e.floor = floor; e.strobes = strobes; e.fault = fault; e.dir = dir;
      exp_q.push_back(e);
   endfunction

   function automatic bit model_move(input bit up);
      bit legal;
      int nf;
      legal = up ? (mfloor < 2) : (mfloor > 0);
      push(EV_ACK, mfloor, -1, !legal, up);
      if (legal) begin
         nf = up ? mfloor + 1 : mfloor - 1;
         push(EV_ARRIVE, nf, TRAVEL, 1'b0, up);
         push(EV_CLOSE,  nf, DOOR,   1'b0, up);
         push(EV_IDLE,   nf, CLOSE,  1'b0, up);
         mfloor = nf;
      end
      return legal;
   endfunction

   function automatic void model_door(input bit reopen);
      push(EV_OPEN,  mfloor, -1,   1'b0, 1'b0);
      push(EV_CLOSE, mfloor, DOOR, 1'b0, 1'b0);
      if (reopen) begin
         push(EV_OPEN,  mfloor, -1,   1'b0, 1'b0);
         push(EV_CLOSE, mfloor, DOOR, 1'b0, 1'b0);
      end
      push(EV_IDLE, mfloor, CLOSE, 1'b0, 1'b0);
   endfunction

   task automatic score(input int kind, input int strobes);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected event kind", kind, -1);
         return;
      end
      e = exp_q.pop_front();
      check("event kind", kind, e.kind);
      check("floorno", int'(bus.floorno), e.floor);
      if (e.strobes >= 0)
         check("strobes in phase", strobes, e.strobes);
      case (kind)
         EV_ACK: begin
            check("fault with ack", int'(bus.fault), int'(e.fault));
            check("moving at ack", int'(bus.moving), int'(!e.fault));
            if (!e.fault)
               check("dir_up latched", int'(bus.dir_up), int'(e.dir));
         end
         EV_ARRIVE: check("arrive moving/door_open", int'({bus.moving, bus.door_open}), 1);
         EV_CLOSE:  check("door_open at close", int'(bus.door_open), 0);
         default: ;
      endcase
   endtask

   // monitor: turns output edges into events and counts strobes per phase
   initial begin
      bit sr, dr, rs, p_open, p_close, seen;
      int strobes, kind;
      p_open = 0; p_close = 0; strobes = 0;
      forever begin
         @(posedge clk);
         sr = bus.slowref; dr = bus.door_req; rs = resetb;
         #1;
         if (!rs) begin
            p_open = 0; p_close = 0; strobes = 0;
            continue;
         end
         if (sr) strobes++;
         seen = 1; kind = -1;
         if (bus.move_ack)                          kind = EV_ACK;
         else if (bus.arrive)                       kind = EV_ARRIVE;
         else if (bus.door_open && !p_open)         kind = EV_OPEN;
         else if (bus.door_closing && !p_close)     kind = EV_CLOSE;
         else if (!bus.door_closing && p_close)     kind = EV_IDLE;
         else                                       seen = 0;
         if (bus.fault && !bus.move_ack)
            check("fault without move_ack", 1, 0);
         if (seen) begin
            score(kind, strobes);
            strobes = 0;
         end else if (p_open && dr && bus.door_open) begin
            strobes = 0;
         end
         p_open = bus.door_open;
         p_close = bus.door_closing;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain timeout pending events", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_ack(input int limit);
      bit got;
      got = 0;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (bus.move_ack) begin
            got = 1;
            break;
         end
      end
      if (!got) check("move_ack timeout", 0, 1);
      @(negedge clk);
      bus.move_req = 1'b0;
   endtask

   task automatic do_move(input bit up, input bit busy);
      bit legal;
      legal = model_move(up);
      @(negedge clk);
      bus.move_req = 1'b1;
      bus.move_up  = up;
      wait_ack(20);
      if (busy && legal) begin
         repeat (2) @(negedge clk);
         bus.move_req = 1'b1;
         bus.move_up  = 1'($urandom);
         repeat (3) @(negedge clk);
         bus.move_req = 1'b0;
      end
      drain();
   endtask

   task automatic door_pulse();
      @(negedge clk);
      bus.door_req = 1'b1;
      @(negedge clk);
      bus.door_req = 1'b0;
   endtask

   task automatic do_door();
      model_door(1'b0);
      door_pulse();
      drain();
   endtask

   task automatic do_reopen();
      bit got;
      model_door(1'b1);
      door_pulse();
      got = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.door_closing) begin
            got = 1;
            break;
         end
      end
      if (!got) check("door_closing timeout", 0, 1);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      door_pulse();
      drain();
   endtask

   // restart the open timer after k strobes; coincident lands on strobe k+1
   task automatic do_restart(input int k, input bit coincident);
      int n;
      model_door(1'b0);
      @(negedge clk);
      bus.door_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.door_req = 1'b0;
      n = 0;
      while (n < k) begin
         @(posedge clk);
         if (bus.slowref) n++;
      end
      if (coincident) repeat (4) @(negedge clk);
      else            @(negedge clk);
      bus.door_req = 1'b1;
      @(negedge clk);
      bus.door_req = 1'b0;
      drain();
   endtask

   task automatic do_simultaneous(input bit up);
      model_door(1'b0);
      void'(model_move(up));
      @(negedge clk);
      bus.door_req = 1'b1;
      bus.move_req = 1'b1;
      bus.move_up  = up;
      @(negedge clk);
      bus.door_req = 1'b0;
      wait_ack(300);
      drain();
   endtask

   task automatic do_reset_mid_move();
      if (mfloor == 0) do_move(1'b1, 1'b0);
      if (mfloor == 2) do_move(1'b0, 1'b0);
      push(EV_ACK, mfloor, -1, 1'b0, 1'b1);
      @(negedge clk);
      bus.move_req = 1'b1;
      bus.move_up  = 1'b1;
      wait_ack(20);
      repeat (6) @(negedge clk);
      check("still moving before reset", int'(bus.moving), 1);
      resetb = 1'b0;
      @(posedge clk);
      #1;
      check("floorno after mid-move reset", int'(bus.floorno), 0);
      check("moving after mid-move reset", int'(bus.moving), 0);
      check("all outputs after mid-move reset",
            int'({bus.move_ack, bus.fault, bus.moving, bus.dir_up, bus.floorno,
                  bus.arrive, bus.door_open, bus.door_closing}), 0);
      exp_q.delete();
      mfloor = 0;
      @(negedge clk);
      resetb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int active;
      resetb = 1'b0;
      bus.move_req = 1'b0;
      bus.move_up  = 1'b0;
      bus.door_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs",
            int'({bus.move_ack, bus.fault, bus.moving, bus.dir_up, bus.floorno,
                  bus.arrive, bus.door_open, bus.door_closing}), 0);
      @(negedge clk);
      resetb = 1'b1;
      active = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if ({bus.move_ack, bus.fault, bus.moving, bus.dir_up, bus.floorno,
              bus.arrive, bus.door_open, bus.door_closing} != '0)
            active++;
      end
      check("idle cycles with output activity", active, 0);

      do_move(1'b1, 1'b0);
      do_move(1'b0, 1'b0);
      do_move(1'b0, 1'b0);
      do_move(1'b1, 1'b0);
      do_move(1'b1, 1'b1);
      do_move(1'b1, 1'b0);
      do_reopen();
      do_restart(5, 1'b1);
      do_restart(2, 1'b0);
      do_simultaneous(1'b0);
      do_simultaneous(1'b1);

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 4))
            0: do_move(1'($urandom), 1'($urandom));
            1: do_door();
            2: do_reopen();
            3: do_restart($urandom_range(1, 5), 1'($urandom));
            default: do_simultaneous(1'($urandom));
         endcase
      end

      do_reset_mid_move();
      do_move(1'b1, 1'b0);
      check("model floor after final move", int'(bus.floorno), mfloor);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
